// File: rtl/split_complex_stream_if.sv
// Stream bundle for split_complex_stream: one complex input stream and the
// two real output streams (I-only and Q-only). The slave modport is the
// splitter's view; master is the surrounding environment's view.
interface split_complex_stream_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] i_tdata;
  logic               i_tlast;
  logic               i_tvalid;
  logic               i_tready;

  logic [2*WIDTH-1:0] oi_tdata;
  logic               oi_tlast;
  logic               oi_tvalid;
  logic               oi_tready;

  logic [2*WIDTH-1:0] oq_tdata;
  logic               oq_tlast;
  logic               oq_tvalid;
  logic               oq_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    output oi_tdata, oi_tlast, oi_tvalid,
    input  oi_tready,
    output oq_tdata, oq_tlast, oq_tvalid,
    input  oq_tready
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    input  oi_tdata, oi_tlast, oi_tvalid,
    output oi_tready,
    input  oq_tdata, oq_tlast, oq_tvalid,
    output oq_tready
  );
endinterface

// File: rtl/split_complex_stream.sv
// Complex-to-real stream splitter. Each accepted {I,Q} beat is written into
// two independent 2-deep lane FIFOs (lane 1 = I, lane 0 = Q); each lane
// drains on its own handshake. Output words carry the component in the
// upper half so a downstream join recombines them unchanged. An optional
// max_len cap forces tlast, and packet / forced-split counters are kept.

// One output lane: 2-entry FIFO holding {last, component}.
module split_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [1:0]   cnt_d_o
);
  logic [1:0][W:0] mem_q, mem_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pop;

  assign out_valid           = (cnt_q != 2'd0);
  assign {out_last, out_data} = mem_q[rd_q];
  assign pop                 = out_valid & pop_ready;
  assign cnt_d_o             = cnt_d;

  // Next state: clear wipes everything; otherwise independent push/pop.
  // The parent never pushes into a full lane, so no overflow guard here.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      mem_d = '0;
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_q] = {push_last, push_data};
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Lane state registers; reset leaves the head entry zero so tdata/tlast read 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module split_complex_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [15:0]            max_len,
  split_complex_stream_if.slave  s,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       split_count
);
  localparam int NUM_LANES = 2;
  localparam int LANE_I    = 1;
  localparam int LANE_Q    = 0;

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_din, lane_dout;
  logic [NUM_LANES-1:0][1:0]       lane_cnt_d;
  logic [NUM_LANES-1:0]            lane_vld, lane_last, lane_rdy;

  logic             rdy_q, rdy_d;
  logic             accept;
  logic             forced;
  logic             out_last;
  logic [15:0]      pos_q, pos_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] split_q, split_d;

  // Packed split of the complex word lines up with lane indices (I high, Q low).
  assign lane_din = s.i_tdata;
  assign lane_rdy = {s.oi_tready, s.oq_tready};
  assign accept   = s.i_tvalid & rdy_q;

  // Cap uses >= so lowering max_len below the current position ends the
  // packet on the very next beat instead of running on.
  assign forced   = (max_len != 16'd0) &&
                    (({1'b0, pos_q} + 17'd1) >= {1'b0, max_len});
  assign out_last = s.i_tlast | forced;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    split_fifo2 #(.W(WIDTH)) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .push      (accept),
      .push_data (lane_din[g]),
      .push_last (out_last),
      .pop_ready (lane_rdy[g]),
      .out_valid (lane_vld[g]),
      .out_data  (lane_dout[g]),
      .out_last  (lane_last[g]),
      .cnt_d_o   (lane_cnt_d[g])
    );
  end

  // Ready for next cycle: every lane will have a free slot. Built from
  // next-state counts and registered, so output readys never reach i_tready
  // combinationally and a full lane blocks input even while it pops.
  always_comb begin
    rdy_d = 1'b1;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_cnt_d[l][1]) rdy_d = 1'b0;
    end
  end

  // Beat position and counters advance on accept; clear wins over accept.
  always_comb begin
    pos_d   = pos_q;
    pkt_d   = pkt_q;
    split_d = split_q;
    if (clear) begin
      pos_d   = '0;
      pkt_d   = '0;
      split_d = '0;
    end else if (accept) begin
      pos_d = out_last ? 16'd0 : pos_q + 16'd1;
      if (out_last)              pkt_d   = pkt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (forced && !s.i_tlast)  split_d = split_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Control registers; i_tready stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q   <= 1'b0;
      pos_q   <= '0;
      pkt_q   <= '0;
      split_q <= '0;
    end else begin
      rdy_q   <= rdy_d;
      pos_q   <= pos_d;
      pkt_q   <= pkt_d;
      split_q <= split_d;
    end
  end

  assign s.i_tready  = rdy_q;
  assign s.oi_tdata  = {lane_dout[LANE_I], {WIDTH{1'b0}}};
  assign s.oi_tlast  = lane_last[LANE_I];
  assign s.oi_tvalid = lane_vld[LANE_I];
  assign s.oq_tdata  = {lane_dout[LANE_Q], {WIDTH{1'b0}}};
  assign s.oq_tlast  = lane_last[LANE_Q];
  assign s.oq_tvalid = lane_vld[LANE_Q];
  assign pkt_count   = pkt_q;
  assign split_count = split_q;
endmodule

// File: tb/tb_split_complex_stream.sv
// Bench for split_complex_stream: directed steps plus a long random run.
// Accepted beats are modelled into per-output expectation queues and
// checked against what each output hands over.
module tb_split_complex_stream;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [15:0]   max_len = 16'd0;
  logic [CW-1:0] pkt_count, split_count;

  split_complex_stream_if #(.WIDTH(W)) bus ();

  split_complex_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .max_len     (max_len),
    .s           (bus.slave),
    .pkt_count   (pkt_count),
    .split_count (split_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [32:0]   qi[$], qq[$];
  bit            lli[$], llq[$];
  int            mpos = 0;
  logic [CW-1:0] m_pkt = '0, m_split = '0;
  int            pops_i = 0, pops_q = 0;
  logic          pvi = 1'b0, pri = 1'b0, pvq = 1'b0, prq = 1'b0;
  logic [32:0]   pdi = '0, pdq = '0;
  logic [32:0]   ei, eq;
  bit            m_forced, m_last;

  task automatic flush_model();
    qi.delete(); qq.delete();
    mpos = 0; m_pkt = '0; m_split = '0;
    pvi = 1'b0; pvq = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      flush_model();
    end else begin
      chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
      chk("split_count", 64'(split_count), 64'(m_split));
      if (pvi && !pri) begin
        chk("oi_hold_valid", 64'(bus.oi_tvalid), 64'd1);
        chk("oi_hold_data", 64'({bus.oi_tlast, bus.oi_tdata}), 64'(pdi));
      end
      if (pvq && !prq) begin
        chk("oq_hold_valid", 64'(bus.oq_tvalid), 64'd1);
        chk("oq_hold_data", 64'({bus.oq_tlast, bus.oq_tdata}), 64'(pdq));
      end
      if (bus.oi_tvalid && bus.oi_tready) begin
        ei = (qi.size() != 0) ? qi.pop_front() : 33'bx;
        chk("oi_beat", 64'({bus.oi_tlast, bus.oi_tdata}), 64'(ei));
        lli.push_back(bus.oi_tlast);
        pops_i++;
      end
      if (bus.oq_tvalid && bus.oq_tready) begin
        eq = (qq.size() != 0) ? qq.pop_front() : 33'bx;
        chk("oq_beat", 64'({bus.oq_tlast, bus.oq_tdata}), 64'(eq));
        llq.push_back(bus.oq_tlast);
        pops_q++;
      end
      if (bus.i_tvalid && bus.i_tready && !clear) begin
        m_forced = (max_len != 16'd0) && (mpos + 1 >= int'(max_len));
        m_last   = bus.i_tlast || m_forced;
        qi.push_back({m_last, bus.i_tdata[31:16], 16'h0000});
        qq.push_back({m_last, bus.i_tdata[15:0], 16'h0000});
        mpos = m_last ? 0 : mpos + 1;
        if (m_last) m_pkt = m_pkt + 1'b1;
        if (m_forced && !bus.i_tlast) m_split = m_split + 1'b1;
      end
      pvi = bus.oi_tvalid; pri = bus.oi_tready; pdi = {bus.oi_tlast, bus.oi_tdata};
      pvq = bus.oq_tvalid; prq = bus.oq_tready; pdq = {bus.oq_tlast, bus.oq_tdata};
      if (clear) flush_model();
    end
  end

  // ---------------- helpers ----------------
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.i_tvalid = 1'b1; bus.i_tdata = d; bus.i_tlast = l;
    forever begin
      @(negedge clk);
      if (bus.i_tready) break;
      n++;
      if (n >= 1000) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qi.size() != 0 || qq.size() != 0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_i_empty", 64'(qi.size()), 64'd0);
    chk("drain_q_empty", 64'(qq.size()), 64'd0);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  function automatic logic [63:0] pack_i();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < lli.size() && i < 64; i++) v[i] = lli[i];
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int base_i, base_q, nacc, cyc;
    bit accd;
    bus.i_tvalid = 1'b0; bus.i_tdata = '0; bus.i_tlast = 1'b0;
    bus.oi_tready = 1'b1; bus.oq_tready = 1'b1;

    // reset state
    #12;
    chk("rst_i_tready", 64'(bus.i_tready), 64'd0);
    chk("rst_oi_tvalid", 64'(bus.oi_tvalid), 64'd0);
    chk("rst_oq_tvalid", 64'(bus.oq_tvalid), 64'd0);
    chk("rst_oi_tdata", 64'(bus.oi_tdata), 64'd0);
    chk("rst_oq_tdata", 64'(bus.oq_tdata), 64'd0);
    chk("rst_oi_tlast", 64'(bus.oi_tlast), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(bus.i_tready), 64'd1);

    // 8-beat packet, both outputs ready
    lli.delete(); llq.delete();
    for (int k = 0; k < 8; k++) begin
      send(32'h1234ABCD + 32'(k) * 32'h00010001, k == 7);
      if (k == 0) begin
        chk("t1_lat_oi_valid", 64'(bus.oi_tvalid), 64'd1);
        chk("t1_lat_oi_data", 64'(bus.oi_tdata), 64'h12340000);
        chk("t1_lat_oq_data", 64'(bus.oq_tdata), 64'hABCD0000);
      end
      chk("t1_ready", 64'(bus.i_tready), 64'd1);
    end
    drain();
    chk("t1_pkt", 64'(pkt_count), 64'd1);
    chk("t1_last_pattern", pack_i(), 64'h80);

    // Q output stalled: I runs ahead 2 beats, then input stalls
    bus.oq_tready = 1'b0;
    base_i = pops_i; base_q = pops_q;
    send(32'hA001B001, 1'b0);
    send(32'hA002B002, 1'b0);
    chk("t2_stall_ready", 64'(bus.i_tready), 64'd0);
    bus.i_tvalid = 1'b1; bus.i_tdata = 32'hA003B003; bus.i_tlast = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t2_oi_pops", 64'(pops_i - base_i), 64'd2);
    chk("t2_oq_pops", 64'(pops_q - base_q), 64'd0);
    chk("t2_still_stalled", 64'(bus.i_tready), 64'd0);
    chk("t2_oq_valid", 64'(bus.oq_tvalid), 64'd1);
    bus.oq_tready = 1'b1;
    send(32'hA003B003, 1'b0);
    send(32'hA004B004, 1'b0);
    send(32'hA005B005, 1'b1);
    drain();
    chk("t2_oi_total", 64'(pops_i - base_i), 64'd5);
    chk("t2_oq_total", 64'(pops_q - base_q), 64'd5);

    // max_len=4 over a 10-beat packet
    clear_pulse();
    max_len = 16'd4;
    lli.delete(); llq.delete();
    for (int k = 0; k < 10; k++) send(32'h00010002 * 32'(k + 1), k == 9);
    drain();
    chk("t3_nbeats", 64'(lli.size()), 64'd10);
    chk("t3_last_pattern", pack_i(), 64'h288);
    chk("t3_pkt", 64'(pkt_count), 64'd3);
    chk("t3_split", 64'(split_count), 64'd2);
    for (int i = 0; i < lli.size() && i < llq.size(); i++)
      chk("t3_last_eq", 64'(llq[i]), 64'(lli[i]));

    // random traffic
    max_len = 16'd0;
    lli.delete(); llq.delete();
    nacc = 0; cyc = 0;
    while (nacc < 10000 && cyc < 60000) begin
      @(negedge clk);
      accd = bus.i_tvalid && bus.i_tready;
      if (accd) nacc++;
      @(posedge clk); #1;
      cyc++;
      bus.oi_tready = ($urandom_range(3) != 0);
      bus.oq_tready = ($urandom_range(3) != 0);
      if (accd || !bus.i_tvalid) begin
        if ($urandom_range(3) != 0) begin
          bus.i_tvalid = 1'b1;
          bus.i_tdata  = $urandom;
          bus.i_tlast  = ($urandom_range(7) == 0);
        end else begin
          bus.i_tvalid = 1'b0;
        end
      end
      if ($urandom_range(63) == 0) begin
        case ($urandom_range(3))
          0: max_len = 16'd0;
          1: max_len = 16'd1;
          2: max_len = 16'd3;
          default: max_len = 16'd7;
        endcase
      end
    end
    chk("t4_beats", 64'(nacc), 64'd10000);
    bus.i_tvalid = 1'b0; bus.oi_tready = 1'b1; bus.oq_tready = 1'b1;
    drain();
    chk("t4_count_eq", 64'(llq.size()), 64'(lli.size()));
    for (int i = 0; i < lli.size() && i < llq.size(); i++)
      chk("t4_last_eq", 64'(llq[i]), 64'(lli[i]));

    // clear mid-packet with both FIFOs full
    clear_pulse();
    max_len = 16'd0;
    send(32'h11112222, 1'b1);
    drain();
    bus.oi_tready = 1'b0; bus.oq_tready = 1'b0;
    send(32'h33334444, 1'b0);
    send(32'h55556666, 1'b0);
    bus.i_tvalid = 1'b1; bus.i_tdata = 32'h77778888; bus.i_tlast = 1'b0;
    chk("t5_full_ready", 64'(bus.i_tready), 64'd0);
    chk("t5_pkt_before", 64'(pkt_count), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; bus.i_tvalid = 1'b0;
    chk("t5_oi_valid", 64'(bus.oi_tvalid), 64'd0);
    chk("t5_oq_valid", 64'(bus.oq_tvalid), 64'd0);
    chk("t5_pkt", 64'(pkt_count), 64'd0);
    chk("t5_split", 64'(split_count), 64'd0);
    chk("t5_ready", 64'(bus.i_tready), 64'd1);
    max_len = 16'd3;
    bus.oi_tready = 1'b1; bus.oq_tready = 1'b1;
    lli.delete(); llq.delete();
    for (int k = 0; k < 3; k++) send(32'h0F0F0000 + 32'(k), 1'b0);
    drain();
    chk("t5_last_pattern", pack_i(), 64'h4);
    chk("t5_split_after", 64'(split_count), 64'd1);

    // asynchronous reset between edges
    max_len = 16'd0;
    bus.oi_tready = 1'b0; bus.oq_tready = 1'b0;
    send(32'hDEADBEEF, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_oi_valid", 64'(bus.oi_tvalid), 64'd0);
    chk("t6_oq_valid", 64'(bus.oq_tvalid), 64'd0);
    chk("t6_oi_data", 64'(bus.oi_tdata), 64'd0);
    chk("t6_oq_data", 64'(bus.oq_tdata), 64'd0);
    chk("t6_ready", 64'(bus.i_tready), 64'd0);
    chk("t6_pkt", 64'(pkt_count), 64'd0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    bus.oi_tready = 1'b1; bus.oq_tready = 1'b1;
    lli.delete(); llq.delete();
    for (int k = 0; k < 4; k++) send(32'hC0DE0000 + 32'(k), k == 3);
    drain();
    chk("t6_pkt_after", 64'(pkt_count), 64'd1);
    chk("t6_split_after", 64'(split_count), 64'd0);
    chk("t6_last_pattern", pack_i(), 64'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/split_complex_stream.md
Name: split_complex_stream

Overview:
- Streaming splitter sitting directly upstream of the two-input join block in the RFNoC receive chain.
- Takes deframed complex samples {I,Q} and produces two independent real streams, I-only and Q-only.
- Each real component goes in the upper half of an output word, so a downstream join recombines it unchanged.
- Adds per-output 2-deep buffering, optional packet-length capping and packet/split counters.

Parameters:
- WIDTH, 16, bits per real component; input word is 2*WIDTH, I in upper half, Q in lower half.
- CNT_W, 16, width of pkt_count and split_count.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of buffers, beat position and counters
- max_len  in  16  max beats per output packet; 0 = no cap; sampled each beat
- i_tdata  in  2*WIDTH  complex sample {I,Q}
- i_tlast  in  1  end of input packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- oi_tdata  out  2*WIDTH  {I, WIDTH'b0}
- oi_tlast  out  1  I-stream end of packet
- oi_tvalid  out  1  I-stream valid
- oi_tready  in  1  I-stream ready
- oq_tdata  out  2*WIDTH  {Q, WIDTH'b0}
- oq_tlast  out  1  Q-stream end of packet
- oq_tvalid  out  1  Q-stream valid
- oq_tready  in  1  Q-stream ready
- pkt_count  out  CNT_W  output packets emitted (wraps)
- split_count  out  CNT_W  packets terminated by max_len rather than i_tlast (wraps)

Behaviour:
- Reset (reset_n low, asynchronous): both buffers empty; oi/oq_tvalid=0, tdata=0, tlast=0; i_tready=0; pos=0; counters=0. i_tready goes 1 on the first clk edge after release.
- Buffers:
  - Each output has a 2-entry FIFO with its own count (0..2).
  - An input accept (i_tvalid & i_tready) writes both FIFOs in the same cycle.
  - i_tready = (cnt_i<2) & (cnt_q<2), a function of registered counts only. No combinational path from oi/oq_tready to i_tready.
  - A full FIFO blocks input even if it pops in the same cycle.
- Output handshakes:
  - Valid = FIFO non-empty; each output pops independently on valid & ready.
  - Data/last stay stable while valid & !ready.
  - Latency: accepted beat appears on both outputs on the next cycle.
  - Throughput: 1 beat/cycle while both outputs are ready.
  - One stalled output lets the other run ahead by at most 2 beats, then input stalls.
- Data mapping:
  - oi_tdata = {i_tdata[2W-1:W], W zeros}.
  - oq_tdata = {i_tdata[W-1:0], W zeros}.
  - No arithmetic or rounding.
- Packet capping:
  - pos counts accepted beats within the current output packet.
  - out_last = i_tlast | (max_len!=0 & pos==max_len-1).
  - out_last is stored with the beat in both FIFOs, so oi_tlast == oq_tlast for every beat.
  - On an accepted out_last beat, pos returns to 0; otherwise pos increments.
  - If max_len is lowered below pos+1 mid-packet, the next accepted beat forces last.
  - max_len=1 makes every beat a last.
- Counters:
  - pkt_count increments on each accepted out_last beat.
  - split_count increments when out_last is forced and i_tlast=0.
  - Both counters wrap from all-ones to 0.
- clear:
  - Synchronous, has priority over a simultaneous accept; the accepted beat is discarded.
  - Next cycle: FIFOs empty, valids 0, pos=0, counters=0, i_tready=1.
- Simultaneous push and pop on a FIFO with count 1 leaves count at 1, with order preserved.

Test Plan:
- Reset then 8-beat packet, i_tdata=0x1234ABCD..., both readys high -> oi_tdata=0x12340000, oq_tdata=0xABCD0000 one cycle after each accept; tlast on beat 8; pkt_count=1; i_tready high throughout.
- Hold oq_tready=0, stream 5 beats -> oi emits 2 beats then i_tready drops after 2 accepts. Release oq -> all 5 beats delivered in order on both outputs, no loss or duplication.
- max_len=4, 10-beat input packet with tlast on beat 10 -> output tlast on beats 4, 8, 10; pkt_count=3; split_count=2.
- Random i_tvalid/oi_tready/oq_tready for 10k beats -> each output sequence matches its scoreboard; oi_tlast==oq_tlast per beat; no valid drop without a pop.
- Assert clear mid-packet with both FIFOs full -> next cycle valids=0, counters=0, i_tready=1. Following packet starts with pos=0, so max_len=3 forces last on its 3rd beat.
- Assert reset_n low asynchronously mid-transfer between clk edges -> outputs go to zero/invalid immediately, without waiting for an edge; the first post-reset packet is processed normally.
